// File: rtl/ws2812_pkg.sv
// ws2812_pkg
//   Shared definitions for the WS2812 frame sequencer: the sequencer state
//   encoding, the number of colour bytes per pixel (G,R,B) and the byte-index
//   type used for RAM addressing and frame length (up to 255 * 3 = 765).
package ws2812_pkg;

  localparam int unsigned BYTES_PER_PIXEL = 3;
  localparam int unsigned BYTE_IDX_W      = 10;

  typedef logic [BYTE_IDX_W-1:0] byte_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    OFFER,
    DRAIN,
    LATCH
  } seq_state_e;

endpackage

// File: rtl/ws2812_down_counter.sv
// ws2812_down_counter
//   Loadable down-counter that saturates at zero. The width is derived from
//   LOAD_VALUE, so the same module serves both the short latch gap and the
//   long holdoff interval.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (count returns to 0)
//   load   in   load LOAD_VALUE on the next edge (wins over decrement)
//   zero   out  count has reached 0
module ws2812_down_counter #(
  parameter int unsigned LOAD_VALUE = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic zero
);

  localparam int unsigned W = (LOAD_VALUE > 0) ? $clog2(LOAD_VALUE + 1) : 1;
  localparam logic [W-1:0] LOAD_W = W'(LOAD_VALUE);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_W;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// ws2812_frame_sequencer
//   Streams the pixel RAM (already stored in wire order G,R,B) byte by byte to
//   the WS2812 bit serializer, one frame at a time, then holds the line idle
//   for the WS2812 latch gap. A frame starts on an explicit refresh request,
//   or automatically when the RAM has been written and the holdoff interval
//   since the previous frame start has elapsed.
//
// Ports:
//   clk               in   system clock
//   reset_n           in   asynchronous active-low reset
//   number_of_pixels  in   strip length, sampled at frame start
//   cpu_access        in   CPU owns the RAM port this cycle
//   cpu_write         in   CPU pixel write strobe (marks RAM dirty)
//   refresh_req       in   single-cycle explicit frame request
//   seq_ram_addr      out  sequencer RAM read address
//   ram_dbi           in   RAM read data, one clock after the address
//   byte_data         out  byte offered to the serializer
//   byte_valid        out  byte_data valid
//   byte_ready        in   serializer accepts the byte on valid & ready
//   ser_idle          in   serializer has shifted out every bit
//   busy              out  frame in progress
//   frame_done        out  one-clock pulse at the end of the latch gap
module ws2812_frame_sequencer
  import ws2812_pkg::*;
#(
  parameter int unsigned MAX_PIXELS   = 4,
  parameter int unsigned LATCH_CLKS   = 8100,
  parameter int unsigned HOLDOFF_CLKS = 270000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] number_of_pixels,
  input  logic       cpu_access,
  input  logic       cpu_write,
  input  logic       refresh_req,
  output logic [9:0] seq_ram_addr,
  input  logic [7:0] ram_dbi,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  input  logic       ser_idle,
  output logic       busy,
  output logic       frame_done
);

  localparam byte_idx_t MAX_PIX = byte_idx_t'(MAX_PIXELS);
  localparam byte_idx_t BPP     = byte_idx_t'(BYTES_PER_PIXEL);

  seq_state_e state_q, state_d;
  byte_idx_t  idx_q, idx_d;
  byte_idx_t  total_q, total_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_valid_q, byte_valid_d;
  logic       dirty_q, dirty_d;
  logic       cpu_access_q, cpu_access_d;

  byte_idx_t  npix_ext;
  byte_idx_t  pix_clamped;
  byte_idx_t  frame_total;
  byte_idx_t  idx_next;
  logic       start;
  logic       holdoff_zero;
  logic       latch_load;
  logic       latch_zero;

  assign npix_ext    = {2'b00, number_of_pixels};
  assign pix_clamped = (npix_ext > MAX_PIX) ? MAX_PIX : npix_ext;
  assign frame_total = pix_clamped * BPP;
  assign idx_next    = idx_q + byte_idx_t'(1);

  // An explicit request bypasses the holdoff; a dirty RAM waits for it.
  assign start      = (state_q == IDLE) && (refresh_req || (dirty_q && holdoff_zero));
  assign latch_load = (state_q == DRAIN) && ser_idle;

  // A write landing in the start cycle must survive, so set wins over clear.
  assign dirty_d      = cpu_write || (dirty_q && !start);
  assign cpu_access_d = cpu_access;

  ws2812_down_counter #(
    .LOAD_VALUE (HOLDOFF_CLKS - 1)
  ) u_holdoff (
    .clk   (clk),
    .rst_n (reset_n),
    .load  (start),
    .zero  (holdoff_zero)
  );

  ws2812_down_counter #(
    .LOAD_VALUE (LATCH_CLKS - 1)
  ) u_latch (
    .clk   (clk),
    .rst_n (reset_n),
    .load  (latch_load),
    .zero  (latch_zero)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    total_d      = total_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = byte_valid_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          total_d = frame_total;
          idx_d   = '0;
          state_d = (frame_total == '0) ? DRAIN : FETCH;
        end
      end

      // The address is only seen by the RAM when the CPU is off the port.
      FETCH: begin
        if (!cpu_access) begin
          state_d = CAPTURE;
        end
      end

      // cpu_access_q reflects the cycle the read was issued in; if the CPU
      // held the port then, ram_dbi belongs to the CPU and must be refetched.
      CAPTURE: begin
        if (cpu_access_q) begin
          state_d = FETCH;
        end else begin
          byte_data_d  = ram_dbi;
          byte_valid_d = 1'b1;
          state_d      = OFFER;
        end
      end

      OFFER: begin
        if (byte_ready) begin
          byte_valid_d = 1'b0;
          idx_d        = idx_next;
          state_d      = (idx_next == total_q) ? DRAIN : FETCH;
        end
      end

      DRAIN: begin
        if (ser_idle) begin
          state_d = LATCH;
        end
      end

      LATCH: begin
        if (latch_zero) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      total_q      <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      dirty_q      <= 1'b1;
      cpu_access_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      total_q      <= total_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      dirty_q      <= dirty_d;
      cpu_access_q <= cpu_access_d;
    end
  end

  assign seq_ram_addr = idx_q;
  assign byte_data    = byte_data_q;
  assign byte_valid   = byte_valid_q;
  assign busy         = (state_q != IDLE);
  assign frame_done   = (state_q == LATCH) && latch_zero;

endmodule

// File: doc/ws2812_frame_sequencer.md
Name: ws2812_frame_sequencer

Overview:
- Moves the pixel RAM contents (GRB byte order, 3 bytes per pixel) to the WS2812 bit serializer, one strip frame at a time.
- Owns the RAM read port whenever the CPU register block is not accessing it.
- Decides when a frame starts: on explicit request, or when the RAM is dirty and the holdoff has elapsed.
- After the last bit, enforces the WS2812 latch (reset) gap.

Parameters:
- MAX_PIXELS, 4, pixel RAM capacity in pixels; byte count is clamped to MAX_PIXELS*3.
- LATCH_CLKS, 8100, minimum idle clocks after the serializer drains (300 us at 27 MHz).
- HOLDOFF_CLKS, 270000, minimum clocks from one frame start to the next dirty-triggered start (10 ms).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- number_of_pixels  in  8  strip length from the register block
- cpu_access  in  1  CPU owns the RAM port this cycle
- cpu_write  in  1  CPU pixel write strobe; sets dirty
- refresh_req  in  1  single-cycle explicit frame request
- seq_ram_addr  out  10  sequencer read address; muxed externally, selected only when cpu_access=0
- ram_dbi  in  8  RAM read data, valid 1 clk after address
- byte_data  out  8  byte to serializer
- byte_valid  out  1  byte_data valid
- byte_ready  in  1  serializer accepts byte when valid&ready
- ser_idle  in  1  serializer has shifted out all bits
- busy  out  1  frame in progress (any state except IDLE)
- frame_done  out  1  one-clk pulse at end of latch gap

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, port reset_n.
- Reset values:
  - state=IDLE, busy=0, frame_done=0, byte_valid=0, byte_data=0, seq_ram_addr=0.
  - dirty=1, so the first frame follows reset.
  - holdoff counter=0, i.e. expired.
- dirty: set by cpu_write in any state; cleared on the cycle a frame starts.
  - If cpu_write occurs in that same cycle, dirty stays 1.
- Holdoff counter: loads HOLDOFF_CLKS-1 at frame start, decrements to 0 and saturates.
- IDLE: start when refresh_req=1, or when dirty=1 and holdoff=0.
  - refresh_req ignores holdoff.
  - refresh_req while busy is dropped; it is not queued.
- Frame start actions:
  - Latch total = min(number_of_pixels, MAX_PIXELS)*3 into a 10-bit count (max 765).
  - idx=0, go to FETCH.
  - If total=0, go straight to DRAIN.
- FETCH: seq_ram_addr=idx.
  - If cpu_access=0, the read is issued; go to CAPTURE.
  - Otherwise stay in FETCH (CPU has priority; retry every cycle).
- CAPTURE: capture ram_dbi into byte_data next edge, assert byte_valid, go to OFFER.
  - If cpu_access was 1 during the read cycle, the captured data is invalid; return to FETCH without asserting valid.
  - This requires cpu_access registered one stage.
- OFFER: byte_valid held, byte_data stable, until byte_ready=1.
  - On handshake: byte_valid=0, idx+1.
  - If idx+1 == total, go to DRAIN; otherwise go to FETCH.
  - Back-to-back minimum is 3 clks per byte.
- DRAIN: wait for ser_idle=1, then load latch counter with LATCH_CLKS-1, go to LATCH.
- LATCH: decrement each clk. At 0: pulse frame_done for 1 clk, go to IDLE.
  - A new start may occur the cycle after frame_done.
- number_of_pixels changes mid-frame have no effect until the next frame.
- Addressing is linear 0..total-1, because RAM order is already wire order (G,R,B).
- Reset mid-frame:
  - Immediately drops byte_valid and busy.
  - dirty=1, so a full frame is resent after release.
  - The serializer is reset by the same reset_n.

Decomposition:
- Shared package ws2812_pkg holds:
  - state enum (IDLE, FETCH, CAPTURE, OFFER, DRAIN, LATCH)
  - BYTES_PER_PIXEL=3
  - the 10-bit byte-index typedef
- One sub-module, ws2812_down_counter: loadable saturating down-counter with zero flag, width derived from its load value. Instantiated twice (holdoff, latch).

Test Plan:
- Basic frame:
  - Stimulus: reset release, MAX_PIXELS=4, number_of_pixels=2, RAM = 0x10..0x1B, byte_ready always 1, ser_idle=1, LATCH_CLKS=16.
  - Response: 6 bytes 0x10..0x15 offered in address order 0..5, then frame_done exactly 16 clks after DRAIN entry.
- CPU contention:
  - Stimulus: hold cpu_access=1 for 5 clks during FETCH of idx 3; also pulse cpu_access during a read cycle.
  - Response: no byte_valid until cpu_access=0; data offered equals RAM[3]; invalidated read is retried with no corrupted byte.
- Serializer backpressure:
  - Stimulus: byte_ready low 20 clks on byte 1; ser_idle low 50 clks after last byte.
  - Response: byte_data stable and byte_valid held throughout; LATCH entered only after ser_idle=1.
- Triggers:
  - Stimulus: cpu_write during a frame, HOLDOFF_CLKS=100.
  - Response: second frame starts exactly 100 clks after first start.
  - Stimulus: refresh_req while busy.
  - Response: ignored.
  - Stimulus: refresh_req in IDLE with holdoff active.
  - Response: starts next clk.
- Limits:
  - Stimulus: number_of_pixels=0.
  - Response: no bytes; frame_done after latch.
  - Stimulus: number_of_pixels=200 with MAX_PIXELS=4.
  - Response: exactly 12 bytes.
- Reset mid-OFFER:
  - Response: byte_valid=0 asynchronously; after release, a full frame is resent from idx 0.
